// File: rtl/mont_exp_param.sv
// mont_exp_param: c = m^e mod n using one shared radix-2 bit-serial Montgomery multiplier
// Ports: clk, rst_n (sync, active-low); start/mode/e/n/m/r2 request inputs latched in IDLE;
// c result (held until next done), busy while working, done one-cycle pulse, err pulse with done on invalid n.
module mont_exp_param #(
    parameter int W     = 256,
    parameter int EXP_W = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [EXP_W-1:0] e,
    input  logic [W-1:0]     n,
    input  logic [W-1:0]     m,
    input  logic [W-1:0]     r2,
    output logic [W-1:0]     c,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CW = $clog2(W + 2);
    localparam int IW = EXP_W > 1 ? $clog2(EXP_W) : 1;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    typedef enum logic [2:0] {IDLE, CHECK, TOMONT, EXP, FROMMONT, DONE} state_t;
    state_t state;
    logic [EXP_W-1:0] e_sh, e_nx;
    logic [W-1:0] n_r, m_r, r2_r, ra, rb, am, op_a, op_b, sq, res;
    logic [W+1:0] s, t, t2, s_it;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic mode_r, ph, bad, eb, dest_ra, last;
    // ra holds C (mode 0) / R0 (mode 1); rb holds S / R1. ph selects the first or second call of a step.
    always_comb begin
        eb      = mode_r ? e_sh[EXP_W-1] : e_sh[0];
        e_nx    = mode_r ? e_sh << 1 : e_sh >> 1;
        sq      = (mode_r && !eb) ? ra : rb;
        op_a    = state == TOMONT ? (ph ? ONE : m_r) : state == EXP ? (ph ? sq : ra) : ra;
        op_b    = state == TOMONT ? r2_r : state == EXP ? (ph ? sq : rb) : ONE;
        dest_ra = state == TOMONT ? ph : state == EXP ? (ph ? (mode_r && !eb) : (!mode_r || eb)) : 1'b1;
        t       = s + (am[0] ? {2'b00, op_b} : '0);
        t2      = t[0] ? t + {2'b00, n_r} : t;
        s_it    = t2 >> 1;
        res     = W'((s >= {2'b00, n_r}) ? s - {2'b00, n_r} : s);
        last    = cnt == CW'(W + 1);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            e_sh   <= '0;
            n_r    <= '0;
            m_r    <= '0;
            r2_r   <= '0;
            ra     <= '0;
            rb     <= '0;
            am     <= '0;
            s      <= '0;
            cnt    <= '0;
            idx    <= '0;
            mode_r <= 1'b0;
            ph     <= 1'b0;
            bad    <= 1'b0;
            c      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    e_sh   <= e;
                    n_r    <= n;
                    m_r    <= m;
                    r2_r   <= r2;
                    mode_r <= mode;
                    bad    <= 1'b0;
                    busy   <= 1'b1;
                    state  <= CHECK;
                end
                CHECK: begin
                    ph <= 1'b0;
                    if (!n_r[0] || n_r < W'(3)) begin
                        ra    <= '0;
                        bad   <= 1'b1;
                        state <= DONE;
                    end else state <= TOMONT;
                end
                TOMONT, EXP, FROMMONT: begin
                    cnt <= last ? '0 : cnt + CW'(1);
                    if (cnt == '0) begin
                        s  <= '0;
                        am <= op_a;
                    end else if (!last) begin
                        s  <= s_it;
                        am <= am >> 1;
                    end else begin
                        if (dest_ra) ra <= res;
                        else rb <= res;
                        // mode 0 skips the multiply call of a step whose exponent bit is 0
                        if (state == FROMMONT) state <= DONE;
                        else if (!ph) ph <= 1'b1;
                        else if (state == TOMONT) begin
                            state <= EXP;
                            idx   <= '0;
                            ph    <= !mode_r && !e_sh[0];
                        end else if (idx == IW'(EXP_W - 1)) state <= FROMMONT;
                        else begin
                            idx  <= idx + IW'(1);
                            e_sh <= e_nx;
                            ph   <= !mode_r && !e_nx[0];
                        end
                    end
                end
                DONE: begin
                    c     <= ra;
                    done  <= 1'b1;
                    err   <= bad;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
